// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - opcode constants OP_NOP .. OP_MUL
//   - condition-code bit indices inside the {C,N,Z} CCR vector
//   - FSM state encoding used by alu_exec_stage
package alu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_NOT   = 4'd1;
    localparam logic [3:0] OP_INC   = 4'd2;
    localparam logic [3:0] OP_DEC   = 4'd3;
    localparam logic [3:0] OP_MOV   = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_SETC  = 4'd11;
    localparam logic [3:0] OP_CLRC  = 4'd12;
    localparam logic [3:0] OP_PASS0 = 4'd13;
    localparam logic [3:0] OP_PASS1 = 4'd14;
    localparam logic [3:0] OP_MUL   = 4'd15;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_stage_mul.sv
// alu_iter_mul: N-cycle shift-add multiplier (unsigned).
// Ports:
//   clk, rst_n      clock / async active-low reset
//   start_i         load operands and begin (ignored while kill_i is high)
//   kill_i          abandon the current multiplication
//   a_i, b_i        N-bit operands
//   busy_o          an iteration is pending this cycle
//   done_o          this cycle performs the final iteration; prod_o is final
//   prod_o          2N-bit product, valid while done_o is high
// start_i in cycle t keeps busy_o high in cycles t+1..t+N; done_o is high
// in cycle t+N so the caller can register the product at that edge.
module alu_iter_mul #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           kill_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] prod_o
);

    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_step;

    // Accumulator after this cycle's iteration; on the final cycle this is
    // the complete product, exposed combinationally to save a cycle.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(1));
    assign prod_o = acc_step;

    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (kill_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = CNT_W'(N);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute-stage ALU with condition-code register.
// Optional multiplier: define ALU_EXEC_MUL_EN to build op 15 as an iterative
// MUL (stalls the front end via in_ready); otherwise op 15 is a NOP and
// in_ready is constant 1.
//
// Ports:
//   clk, rst_n           clock / async active-low reset
//   in_valid, in_ready   operation handshake (accepted when both high)
//   op, in_src, in_dst   opcode and operands
//   shamt                immediate shift amount
//   flush                drop the in-flight and same-cycle operation
//   flags_load, flags_in restore CCR ({C,N,Z}); wins over ALU flag updates
//   out_valid, out       registered result, one-cycle valid pulse
//   flags                registered CCR {C,N,Z}
//
// FSM (only present with ALU_EXEC_MUL_EN):
//   state       | meaning
//   ST_IDLE     | accepting ops; single-cycle ops complete next cycle
//   ST_MUL_BUSY | multiplier iterating; in_ready low
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int N       = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [N-1:0]       in_src,
    input  logic [N-1:0]       in_dst,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    input  logic               flags_load,
    input  logic [2:0]         flags_in,
    output logic               out_valid,
    output logic [N-1:0]       out,
    output logic [2:0]         flags
);

    logic [N-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [2:0]   ccr_q, ccr_d;
    logic         accept;

    logic [N-1:0] alu_res;
    logic         alu_c;
    logic         alu_valid;
    logic         alu_upd_zn;
    logic [N:0]   sum_w;
    logic [N:0]   shl_w;
    logic [N:0]   shr_w;
    logic         shamt_big;
    logic         shamt_zero;

`ifdef ALU_EXEC_MUL_EN
    alu_state_e     state_q, state_d;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;

    alu_iter_mul #(
        .N (N)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .kill_i  (flush),
        .a_i     (in_src),
        .b_i     (in_dst),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    assign in_ready = (state_q == ST_IDLE) && !mul_busy;
`else
    assign in_ready = 1'b1;
`endif

    assign accept = in_valid && in_ready && !flush;

    // The extra bit on the shift vectors catches the last bit shifted out:
    // bit N for left shifts, bit 0 for right shifts.
    assign shl_w      = {1'b0, in_src} << shamt;
    assign shr_w      = {in_src, 1'b0} >> shamt;
    assign shamt_big  = {1'b0, shamt} >= (SHAMT_W + 1)'(N);
    assign shamt_zero = (shamt == '0);

    always_comb begin
        alu_res    = out_q;
        alu_c      = ccr_q[FLAG_C];
        alu_valid  = 1'b0;
        alu_upd_zn = 1'b0;
        sum_w      = '0;
        case (op)
            OP_NOT: begin
                alu_res    = ~in_src;
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_INC: begin
                sum_w      = {1'b0, in_src} + (N + 1)'(1);
                alu_res    = sum_w[N-1:0];
                alu_c      = sum_w[N];
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_DEC: begin
                // bit N of the wrapped difference is the borrow
                sum_w      = {1'b0, in_src} - (N + 1)'(1);
                alu_res    = sum_w[N-1:0];
                alu_c      = sum_w[N];
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_MOV: begin
                alu_res   = in_dst;
                alu_valid = 1'b1;
            end
            OP_ADD: begin
                sum_w      = {1'b0, in_src} + {1'b0, in_dst};
                alu_res    = sum_w[N-1:0];
                alu_c      = sum_w[N];
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_SUB: begin
                sum_w      = {1'b0, in_src} - {1'b0, in_dst};
                alu_res    = sum_w[N-1:0];
                alu_c      = sum_w[N];
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_AND: begin
                alu_res    = in_src & in_dst;
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_OR: begin
                alu_res    = in_src | in_dst;
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OP_SHL: begin
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
                if (shamt_zero) begin
                    alu_res = in_src;
                end else if (shamt_big) begin
                    alu_res = '0;
                    alu_c   = in_src[N-1];
                end else begin
                    alu_res = shl_w[N-1:0];
                    alu_c   = shl_w[N];
                end
            end
            OP_SHR: begin
                alu_valid  = 1'b1;
                alu_upd_zn = 1'b1;
                if (shamt_zero) begin
                    alu_res = in_src;
                end else if (shamt_big) begin
                    alu_res = '0;
                    alu_c   = in_src[0];
                end else begin
                    alu_res = shr_w[N:1];
                    alu_c   = shr_w[0];
                end
            end
            OP_SETC: begin
                alu_c     = 1'b1;
                alu_valid = 1'b1;
            end
            OP_CLRC: begin
                alu_c     = 1'b0;
                alu_valid = 1'b1;
            end
            OP_PASS0, OP_PASS1: begin
                alu_res   = in_src;
                alu_valid = 1'b1;
            end
            default: begin
                // NOP, and MUL which is handled by the FSM
            end
        endcase
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        ccr_d       = ccr_q;
`ifdef ALU_EXEC_MUL_EN
        state_d     = state_q;
        mul_start   = 1'b0;
`endif
        if (!flush) begin
            if (accept && alu_valid) begin
                out_d         = alu_res;
                out_valid_d   = 1'b1;
                ccr_d[FLAG_C] = alu_c;
                if (alu_upd_zn) begin
                    ccr_d[FLAG_Z] = (alu_res == '0);
                    ccr_d[FLAG_N] = alu_res[N-1];
                end
            end
`ifdef ALU_EXEC_MUL_EN
            case (state_q)
                ST_IDLE: begin
                    if (accept && (op == OP_MUL)) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_BUSY;
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done) begin
                        out_d         = mul_prod[N-1:0];
                        out_valid_d   = 1'b1;
                        ccr_d[FLAG_C] = |mul_prod[2*N-1:N];
                        ccr_d[FLAG_Z] = (mul_prod[N-1:0] == '0);
                        ccr_d[FLAG_N] = mul_prod[N-1];
                        state_d       = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = ST_IDLE;
`endif
        end
        if (flags_load) begin
            ccr_d = flags_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ccr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ccr_q       <= ccr_d;
        end
    end

`ifdef ALU_EXEC_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign flags     = ccr_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int N       = 16;
    localparam int SHAMT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         op;
    logic [N-1:0]       in_src;
    logic [N-1:0]       in_dst;
    logic [SHAMT_W-1:0] shamt;
    logic               flush;
    logic               flags_load;
    logic [2:0]         flags_in;
    logic               out_valid;
    logic [N-1:0]       out;
    logic [2:0]         flags;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_stage #(.N(N), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .in_src     (in_src),
        .in_dst     (in_dst),
        .shamt      (shamt),
        .flush      (flush),
        .flags_load (flags_load),
        .flags_in   (flags_in),
        .out_valid  (out_valid),
        .out        (out),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] out;
        logic        valid;
        logic [2:0]  fl;        // {C,N,Z}
        int          mul_left;  // cycles of stall remaining
        logic [31:0] mul_full;  // full product of the pending MUL
    } mst_t;

    mst_t m;

    function automatic mst_t step(input mst_t s, input logic v, input logic [3:0] o,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] sh, input logic fl_, input logic ld,
                                  input logic [2:0] fin);
        mst_t n;
        int unsigned ua, ub, t;
        logic [15:0] r;
        logic c;
        bit res, zn;
        n = s;
        n.valid = 1'b0;
        ua = a;
        ub = b;
        r = s.out;
        c = s.fl[2];
        res = 1'b0;
        zn = 1'b0;
        if (fl_) begin
            n.mul_left = 0;
        end else if (s.mul_left == 1) begin
            n.out = s.mul_full[15:0];
            n.valid = 1'b1;
            n.fl = {s.mul_full[31:16] != 16'h0, s.mul_full[15], s.mul_full[15:0] == 16'h0};
            n.mul_left = 0;
        end else if (s.mul_left > 1) begin
            n.mul_left = s.mul_left - 1;
        end else if (v) begin
            res = 1'b1;
            zn = 1'b1;
            case (o)
                OP_NOT: r = ~a;
                OP_INC: begin t = ua + 1; r = t[15:0]; c = (t > 32'hFFFF); end
                OP_DEC: begin r = a - 16'd1; c = (ua < 1); end
                OP_MOV: begin r = b; zn = 1'b0; end
                OP_ADD: begin t = ua + ub; r = t[15:0]; c = (t > 32'hFFFF); end
                OP_SUB: begin r = a - b; c = (ua < ub); end
                OP_AND: r = a & b;
                OP_OR:  r = a | b;
                OP_SHL: begin
                    if (sh == 4'd0) r = a;
                    else if (int'(sh) >= N) begin r = 16'h0; c = a[15]; end
                    else begin
                        t = ua << sh; r = t[15:0];
                        t = ua >> (N - int'(sh)); c = t[0];
                    end
                end
                OP_SHR: begin
                    if (sh == 4'd0) r = a;
                    else if (int'(sh) >= N) begin r = 16'h0; c = a[0]; end
                    else begin
                        t = ua >> sh; r = t[15:0];
                        t = ua >> (int'(sh) - 1); c = t[0];
                    end
                end
                OP_SETC: begin c = 1'b1; zn = 1'b0; end
                OP_CLRC: begin c = 1'b0; zn = 1'b0; end
                OP_PASS0, OP_PASS1: begin r = a; zn = 1'b0; end
`ifdef ALU_EXEC_MUL_EN
                OP_MUL: begin
                    res = 1'b0;
                    n.mul_left = N;
                    n.mul_full = ua * ub;
                end
`endif
                default: res = 1'b0;
            endcase
            if (res) begin
                n.out = r;
                n.valid = 1'b1;
                n.fl[2] = c;
                if (zn) begin
                    n.fl[0] = (r == 16'h0);
                    n.fl[1] = r[15];
                end
            end
        end
        if (ld) n.fl = fin;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, in_valid, op, in_src, in_dst, shamt, flush, flags_load, flags_in);
    end

    // compare process: DUT against the model every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_valid", 32'(out_valid), 32'(m.valid));
            chk("cyc_out",   32'(out),       32'(m.out));
            chk("cyc_flags", 32'(flags),     32'(m.fl));
            chk("cyc_ready", 32'(in_ready),  32'(m.mul_left == 0));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] s;
        logic [15:0] d;
        logic [3:0]  sh;
        logic [15:0] eo;
        logic [2:0]  ef;   // {C,N,Z}
        logic        ev;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic issue(input logic [3:0] o, input logic [15:0] s, input logic [15:0] d,
                         input logic [3:0] sh);
        op = o; in_src = s; in_dst = d; shamt = sh; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pin(input string nm, input logic [15:0] eo, input logic [2:0] ef,
                       input logic ev);
        chk({nm, "_out"},   32'(out),       32'(eo));
        chk({nm, "_flags"}, 32'(flags),     32'(ef));
        chk({nm, "_valid"}, 32'(out_valid), 32'(ev));
        chk({nm, "_model"}, {m.out, 12'h0, m.fl, m.valid}, {eo, 12'h0, ef, ev});
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0]  = '{OP_ADD,   16'hFFFF, 16'h0001, 4'd0,  16'h0000, 3'b101, 1'b1};
        vecs[1]  = '{OP_SUB,   16'h0003, 16'h0005, 4'd0,  16'hFFFE, 3'b110, 1'b1};
        vecs[2]  = '{OP_MOV,   16'h0000, 16'h1234, 4'd0,  16'h1234, 3'b110, 1'b1};
        vecs[3]  = '{OP_SHL,   16'h8001, 16'h0000, 4'd1,  16'h0002, 3'b100, 1'b1};
        vecs[4]  = '{OP_SHR,   16'h0001, 16'h0000, 4'd0,  16'h0001, 3'b100, 1'b1};
        vecs[5]  = '{OP_SHR,   16'h8000, 16'h0000, 4'd15, 16'h0001, 3'b000, 1'b1};
        vecs[6]  = '{OP_NOT,   16'h00FF, 16'h0000, 4'd0,  16'hFF00, 3'b010, 1'b1};
        vecs[7]  = '{OP_INC,   16'hFFFF, 16'h0000, 4'd0,  16'h0000, 3'b101, 1'b1};
        vecs[8]  = '{OP_DEC,   16'h0000, 16'h0000, 4'd0,  16'hFFFF, 3'b110, 1'b1};
        vecs[9]  = '{OP_AND,   16'hF0F0, 16'h0F0F, 4'd0,  16'h0000, 3'b101, 1'b1};
        vecs[10] = '{OP_OR,    16'hF000, 16'h000F, 4'd0,  16'hF00F, 3'b110, 1'b1};
        vecs[11] = '{OP_CLRC,  16'h1111, 16'h2222, 4'd0,  16'hF00F, 3'b010, 1'b1};
        vecs[12] = '{OP_SETC,  16'h1111, 16'h2222, 4'd0,  16'hF00F, 3'b110, 1'b1};
        vecs[13] = '{OP_NOP,   16'h1111, 16'h2222, 4'd0,  16'hF00F, 3'b110, 1'b0};
        vecs[14] = '{OP_PASS0, 16'h5A5A, 16'h0000, 4'd0,  16'h5A5A, 3'b110, 1'b1};
        vecs[15] = '{OP_PASS1, 16'h0000, 16'h0000, 4'd0,  16'h0000, 3'b110, 1'b1};
        vecs[16] = '{OP_INC,   16'h7FFF, 16'h0000, 4'd0,  16'h8000, 3'b010, 1'b1};
        vecs[17] = '{OP_SUB,   16'h0005, 16'h0003, 4'd0,  16'h0002, 3'b000, 1'b1};
        vecs[18] = '{OP_ADD,   16'h8000, 16'h8000, 4'd0,  16'h0000, 3'b101, 1'b1};
        vecs[19] = '{OP_SHL,   16'h0001, 16'h0000, 4'd15, 16'h8000, 3'b010, 1'b1};
        vecs[20] = '{OP_SHR,   16'h0003, 16'h0000, 4'd1,  16'h0001, 3'b100, 1'b1};
        vecs[21] = '{OP_DEC,   16'h0001, 16'h0000, 4'd0,  16'h0000, 3'b001, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; op = OP_NOP; in_src = '0; in_dst = '0;
        shamt = '0; flush = 1'b0; flags_load = 1'b0; flags_in = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pin("reset", 16'h0000, 3'b000, 1'b0);
        chk("reset_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].s, vecs[i].d, vecs[i].sh);
            pin($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ef, vecs[i].ev);
        end

`ifdef ALU_EXEC_MUL_EN
        issue(OP_MUL, 16'h0100, 16'h0100, 4'd0);
        chk("mul1_ready_low", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("mul1_latency", 32'(lat), 32'(N));
        pin("mul1", 16'h0000, 3'b101, 1'b1);
        chk("mul1_ready_back", 32'(in_ready), 32'd1);

        issue(OP_MUL, 16'h0007, 16'h0006, 4'd0);
        wait_valid(lat);
        chk("mul2_latency", 32'(lat), 32'(N));
        pin("mul2", 16'h002A, 3'b000, 1'b1);

        // flush during a MUL at t+5
        issue(OP_MUL, 16'h0003, 16'h0003, 4'd0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        pin("mulflush", 16'h002A, 3'b000, 1'b0);
        chk("mulflush_ready", 32'(in_ready), 32'd1);
        repeat (20) @(negedge clk);
        issue(OP_ADD, 16'h0010, 16'h0020, 4'd0);
        pin("post_flush_add", 16'h0030, 3'b000, 1'b1);

        // reset in the middle of a MUL
        issue(OP_MUL, 16'h0005, 16'h0005, 4'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mulrst_valid", 32'(out_valid), 32'd0);
        chk("mulrst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        // without the multiplier op 15 is a NOP that never stalls
        issue(OP_MUL, 16'h0007, 16'h0006, 4'd0);
        pin("op15_nop", 16'h0000, 3'b001, 1'b0);
        chk("op15_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("op15_quiet", 32'(out_valid), 32'd0);
`endif

        // set known flags, then an op killed by a same-cycle flush
        issue(OP_SUB, 16'h0003, 16'h0005, 4'd0);
        pin("preflush", 16'hFFFE, 3'b110, 1'b1);
        flush = 1'b1;
        issue(OP_ADD, 16'h0000, 16'h0000, 4'd0);
        flush = 1'b0;
        pin("flush_drop", 16'hFFFE, 3'b110, 1'b0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        issue(OP_ADD, 16'h0002, 16'h0003, 4'd0);
        pin("after_flush", 16'h0005, 3'b000, 1'b1);

        // flags_load beats the ALU's flag update
        flags_load = 1'b1; flags_in = 3'b101;
        issue(OP_ADD, 16'h0001, 16'h0001, 4'd0);
        flags_load = 1'b0; flags_in = 3'b000;
        pin("flags_load", 16'h0002, 3'b101, 1'b1);

        // asynchronous reset while a result is being presented
        issue(OP_ADD, 16'hFFFF, 16'h0001, 4'd0);
        pin("prereset", 16'h0000, 3'b101, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_INC, 16'h0041, 16'h0000, 4'd0);
        pin("post_reset", 16'h0042, 3'b000, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute-stage ALU for the pipelined processor. It is the parametrised successor of the combinational ALU and adds:
- configurable data width and shift-amount width,
- an internal condition-code register (CCR: Z, N, C) that holds its value for non-ALU ops,
- logical shifts using an immediate amount,
- a multi-cycle iterative multiplier that stalls the front end through a ready/valid handshake.

It sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- N, 16, datapath width in bits (at least 4).
- SHAMT_W, 4, width of the immediate shift amount (2**SHAMT_W must be at least N).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operation presented this cycle.
- in_ready, output, 1, stage can accept an operation.
- op, input, 4, operation code.
- in_src, input, N, source operand.
- in_dst, input, N, destination operand.
- shamt, input, SHAMT_W, immediate shift amount.
- flush, input, 1, kill the in-flight operation (branch or interrupt).
- flags_load, input, 1, load the CCR from flags_in (RTI restore).
- flags_in, input, 3, {C,N,Z} restore value.
- out_valid, output, 1, result valid this cycle.
- out, output, N, registered result.
- flags, output, 3, registered CCR as {C,N,Z}.

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, out_valid=0, flags=3'b000, in_ready=1, FSM=IDLE, multiplier registers cleared.
- An operation is accepted on any edge where in_valid and in_ready are both high.
- Single-cycle ops accepted in cycle t: out, out_valid and the CCR update in cycle t+1. out_valid is a one-cycle pulse per accepted op.

Opcodes:
- 0 NOP: no result, out_valid stays 0, flags unchanged.
- 1 NOT: ~src.
- 2 INC: src+1.
- 3 DEC: src-1.
- 4 MOV: result is dst; flags unchanged.
- 5 ADD: src+dst.
- 6 SUB: src-dst.
- 7 AND: src&dst.
- 8 OR: src|dst.
- 9 SHL: src<<shamt.
- 10 SHR: src>>shamt, logical.
- 11 SETC: C=1; out holds its previous value; Z and N unchanged; out_valid=1.
- 12 CLRC: C=0; otherwise as SETC.
- 13 and 14 PASS: result is src; flags unchanged.
- 15 MUL: see the optional feature.

Carry rules:
- Arithmetic ops compute in N+1 bits and take C from bit N. For SUB and DEC this bit is the borrow, so 3-5 gives C=1.
- NOT, AND and OR leave C unchanged.
- SHL and SHR set C to the last bit shifted out.
- shamt=0 gives result=src with C unchanged.
- shamt at least N gives result=0, with C equal to src[N-1] for SHL or src[0] for SHR.

Z and N flags:
- Updated (Z = result==0, N = result[N-1]) for opcodes 1-3 and 5-10 only.

FSM:
- States are IDLE and MUL_BUSY.
- IDLE goes to MUL_BUSY when op 15 is accepted; in_ready drops the following cycle.
- MUL_BUSY uses an N-iteration shift-add with a down-counter.
- On the last iteration the FSM returns to IDLE and out_valid is asserted.
- Op 15 accepted in cycle t: result in cycle t+N+1; in_ready is low in cycles t+1..t+N and high again in t+N+1.

Flush:
- Forces FSM=IDLE, out_valid=0 and in_ready=1 on the next edge.
- No CCR update from the killed op.
- An op presented in the same cycle as flush is also dropped.

flags_load:
- Overrides any same-cycle ALU flag update.
- The ALU's out and out_valid still update normally.

Reset mid-MUL: returns immediately to the reset values above.

Optional Feature:
Macro ALU_EXEC_MUL_EN.
- Defined: op 15 is MUL. out is the low N bits of src*dst. C = OR of the high N bits (overflow). Z and N are computed from the low N bits.
- Undefined: the multiplier and MUL_BUSY state are not built. Op 15 behaves as NOP, in_ready is tied to 1, and the FSM reduces to IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants OP_NOP .. OP_MUL,
  - the CCR bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2,
  - the FSM state encoding.
- One sub-module, alu_iter_mul: parametrised N-cycle shift-add multiplier with start, busy, done and kill ports. It is instantiated only under ALU_EXEC_MUL_EN.

Test Plan:
- ADD 0xFFFF+0x0001 accepted at t -> at t+1 out=0x0000, out_valid=1, flags C=1, N=0, Z=1.
- SUB 0x0003-0x0005, then MOV dst=0x1234 -> first out=0xFFFE with C=1, N=1, Z=0; MOV gives out=0x1234 with flags still C=1, N=1, Z=0.
- SHL 0x8001 shamt=1 -> out=0x0002, C=1. SHR 0x0001 shamt=0 -> out=0x0001, C unchanged. SHR 0x8000 shamt=15 -> out=0x0001, C=0.
- MUL 0x0100*0x0100 (macro on) -> in_ready low for 16 cycles, out=0x0000, C=1, Z=1 at t+17. MUL 7*6 -> out=0x002A, C=0.
- flush asserted at t+5 of a MUL -> no out_valid, flags unchanged, in_ready=1 at t+6, next ADD completes normally.
- flags_load with flags_in=3'b101 in the same cycle as an accepted ADD 1+1 -> out=0x0002, out_valid=1, flags=3'b101. Drop rst_n mid-op -> flags=0 and out_valid=0 immediately.
